// File: rtl/slot_addr_seq.sv
// Slot address sequencer: splits a run into NUM_SLOTS slots of slot_len cycles
// and emits a registered address per slot. Optional remap table: SLOT_ADDR_REMAP_EN.
module slot_addr_seq #(
  parameter int ADDR_W    = 4,
  parameter int NUM_SLOTS = 16,
  parameter int LEN_W     = 10,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              mode_loop,
  input  logic [LEN_W-1:0]  slot_len,
  input  logic              map_we,
  input  logic [SLOT_W-1:0] map_idx,
  input  logic [ADDR_W-1:0] map_data,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              slot_strobe,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               loop_q, loop_d;
  logic [LEN_W-1:0]   phase_q, phase_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               addr_valid_q, addr_valid_d;
  logic               slot_strobe_q, slot_strobe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

`ifdef SLOT_ADDR_REMAP_EN
  logic [ADDR_W-1:0]  map_q [NUM_SLOTS];
  logic [ADDR_W-1:0]  map_d [NUM_SLOTS];

  always_comb begin
    map_d = map_q;
    if (map_we && (int'(map_idx) < NUM_SLOTS)) begin
      map_d[map_idx] = map_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        map_q[i] <= ADDR_W'(i);
      end
    end else begin
      map_q <= map_d;
    end
  end
`else
  logic unused_map;
  assign unused_map = ^{map_we, map_idx, map_data};
`endif

  // Slot entry reads the table as registered, so a same-cycle write is not seen.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [SLOT_W-1:0] idx);
`ifdef SLOT_ADDR_REMAP_EN
    return map_q[idx];
`else
    return ADDR_W'(idx);
`endif
  endfunction

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    loop_d        = loop_q;
    phase_d       = phase_q;
    slot_d        = slot_q;
    addr_d        = addr_q;
    addr_valid_d  = addr_valid_q;
    slot_strobe_d = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        addr_d       = '0;
        addr_valid_d = 1'b0;
        busy_d       = 1'b0;
        phase_d      = '0;
        slot_d       = '0;
        if (start && !stop) begin
          len_d         = (slot_len == '0) ? LEN_ONE : slot_len;
          loop_d        = mode_loop;
          state_d       = RUN;
          addr_d        = slot_addr('0);
          addr_valid_d  = 1'b1;
          busy_d        = 1'b1;
          slot_strobe_d = 1'b1;
        end
      end

      RUN: begin
        if (stop) begin
          state_d      = IDLE;
          addr_d       = '0;
          addr_valid_d = 1'b0;
          busy_d       = 1'b0;
          phase_d      = '0;
          slot_d       = '0;
        end else if (phase_q == len_q - LEN_ONE) begin
          if (slot_q != LAST_SLOT) begin
            slot_d        = slot_q + 1'b1;
            phase_d       = '0;
            addr_d        = slot_addr(slot_q + 1'b1);
            slot_strobe_d = 1'b1;
          end else if (loop_q) begin
            slot_d        = '0;
            phase_d       = '0;
            addr_d        = slot_addr('0);
            slot_strobe_d = 1'b1;
          end else begin
            state_d      = IDLE;
            addr_d       = '0;
            addr_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            phase_d      = '0;
            slot_d       = '0;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      len_q         <= LEN_ONE;
      loop_q        <= 1'b0;
      phase_q       <= '0;
      slot_q        <= '0;
      addr_q        <= '0;
      addr_valid_q  <= 1'b0;
      slot_strobe_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      loop_q        <= loop_d;
      phase_q       <= phase_d;
      slot_q        <= slot_d;
      addr_q        <= addr_d;
      addr_valid_q  <= addr_valid_d;
      slot_strobe_q <= slot_strobe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign addr        = addr_q;
  assign addr_valid  = addr_valid_q;
  assign slot_strobe = slot_strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_slot_addr_seq.sv
// Directed bench for slot_addr_seq: one-shot, loop, zero length, reset/ignored
// requests and remap (expected last address follows SLOT_ADDR_REMAP_EN).
module tb_slot_addr_seq;

  localparam int ADDR_W    = 4;
  localparam int NUM_SLOTS = 16;
  localparam int LEN_W     = 10;
  localparam int SLOT_W    = 4;

`ifdef SLOT_ADDR_REMAP_EN
  localparam logic [ADDR_W-1:0] REMAP_LAST = 4'd2;
`else
  localparam logic [ADDR_W-1:0] REMAP_LAST = 4'd15;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic              mode_loop;
  logic [LEN_W-1:0]  slot_len;
  logic              map_we;
  logic [SLOT_W-1:0] map_idx;
  logic [ADDR_W-1:0] map_data;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              slot_strobe;
  logic              busy;
  logic              done;

  int checks;
  int failures;
  int strobe_cnt;
  logic [ADDR_W-1:0] exp_q[$];

  slot_addr_seq #(
    .ADDR_W   (ADDR_W),
    .NUM_SLOTS(NUM_SLOTS),
    .LEN_W    (LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode_loop  (mode_loop),
    .slot_len   (slot_len),
    .map_we     (map_we),
    .map_idx    (map_idx),
    .map_data   (map_data),
    .addr       (addr),
    .addr_valid (addr_valid),
    .slot_strobe(slot_strobe),
    .busy       (busy),
    .done       (done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, "_addr"},  32'(addr), 32'd0);
    check({tag, "_valid"}, 32'(addr_valid), 32'd0);
    check({tag, "_strb"},  32'(slot_strobe), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'(exp_done));
  endtask

  task automatic start_run(input int len_in, input logic loop_in);
    slot_len  = LEN_W'(len_in);
    mode_loop = loop_in;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Checks cycles first..last after start (cycle 1 = first RUN cycle), ticking after each.
  task automatic run_check(input string tag, input int len_eff, input logic loop_run,
                           input int first, input int last, input logic [ADDR_W-1:0] last_addr);
    int slot;
    logic [ADDR_W-1:0] exp_a;
    exp_q.delete();
    for (int c = first; c <= last; c++) begin
      slot = ((c - 1) / len_eff) % NUM_SLOTS;
      exp_q.push_back((slot == NUM_SLOTS - 1) ? last_addr : ADDR_W'(slot));
    end
    for (int c = first; c <= last; c++) begin
      exp_a = exp_q.pop_front();
      if (!loop_run && c > NUM_SLOTS * len_eff) begin
        check_idle(tag, (c == NUM_SLOTS * len_eff + 1) ? 1'b1 : 1'b0);
      end else begin
        check({tag, "_addr"},  32'(addr), 32'(exp_a));
        check({tag, "_valid"}, 32'(addr_valid), 32'd1);
        check({tag, "_busy"},  32'(busy), 32'd1);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_strb"},  32'(slot_strobe), ((c - 1) % len_eff == 0) ? 32'd1 : 32'd0);
      end
      if (slot_strobe) strobe_cnt++;
      tick();
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    mode_loop = 1'b0;
    slot_len  = '0;
    map_we    = 1'b0;
    map_idx   = '0;
    map_data  = '0;

    // Reset state
    tick();
    tick();
    check_idle("rst", 1'b0);
    rst_n = 1'b1;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("stop_idle", 1'b0);

    // One-shot, len 13: 208 busy cycles, done on cycle 209
    strobe_cnt = 0;
    start_run(13, 1'b0);
    run_check("t1", 13, 1'b0, 1, 210, 4'd15);
    check("t1_strobes", 32'(strobe_cnt), 32'd16);

    // Loop, len 3: wraps to slot 0 with strobe; stop aborts without done
    start_run(3, 1'b1);
    run_check("t2", 3, 1'b1, 1, 60, 4'd15);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("t2_stop", 1'b0);
    tick();
    check_idle("t2_after", 1'b0);

    // Zero length behaves as one: done on cycle 17
    strobe_cnt = 0;
    start_run(0, 1'b0);
    run_check("t3", 1, 1'b0, 1, 18, 4'd15);
    check("t3_strobes", 32'(strobe_cnt), 32'd16);

    // Start/len/mode changes during RUN ignored; reset mid-slot 7
    start_run(5, 1'b0);
    run_check("t4a", 5, 1'b0, 1, 9, 4'd15);
    start     = 1'b1;
    slot_len  = LEN_W'(2);
    mode_loop = 1'b1;
    run_check("t4b", 5, 1'b0, 10, 10, 4'd15);
    start = 1'b0;
    run_check("t4c", 5, 1'b0, 11, 37, 4'd15);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("t4_rst", 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_idle("t4_startstop", 1'b0);
    start_run(4, 1'b0);
    run_check("t4_restart", 4, 1'b0, 1, 9, 4'd15);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("t4_stop", 1'b0);

    // Remap last entry, then reset restores identity
    map_we   = 1'b1;
    map_idx  = 4'd15;
    map_data = 4'd2;
    tick();
    map_we = 1'b0;
    start_run(13, 1'b0);
    run_check("t5_map", 13, 1'b0, 1, 210, REMAP_LAST);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("t5_rst", 1'b0);
    start_run(1, 1'b0);
    run_check("t5_ident", 1, 1'b0, 1, 18, 4'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
